// File: rtl/wb_cmd_sequencer.sv
// wb_cmd_sequencer: turns 34-bit command words into single pipelined Wishbone
// transfers and returns one 34-bit response word per command. Rev 1.0
`default_nettype none

module wb_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_INC       = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_stb,
  input  logic [33:0] i_cmd_word,
  output logic        o_cmd_busy,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic        o_rsp_stb,
  output logic [33:0] o_rsp_word,
  input  logic        i_rsp_busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUS      = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  localparam int          CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [31:0]   addr_reg;
  logic [CW-1:0] tmo_cnt;

  logic        bus_active;
  logic        handshake_ok;
  logic        take_err;
  logic        take_ack;
  logic        timed_out;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;

  assign cmd_op   = i_cmd_word[33:32];
  assign cmd_data = i_cmd_word[31:0];

  // A slave response only counts once the request has actually been taken
  // (stall low in BUS) or while waiting for the ack; err dominates ack.
  assign bus_active   = (state == BUS) || (state == WAIT_ACK);
  assign handshake_ok = bus_active && ((state == WAIT_ACK) || !i_wb_stall);
  assign take_err     = handshake_ok && i_wb_err;
  assign take_ack     = handshake_ok && i_wb_ack && !i_wb_err;
  assign timed_out    = bus_active && !take_err && !take_ack && (tmo_cnt == LAST);

  assign o_cmd_busy = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      addr_reg   <= 32'd0;
      tmo_cnt    <= '0;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_addr  <= 32'd0;
      o_wb_data  <= 32'd0;
      o_rsp_stb  <= 1'b0;
      o_rsp_word <= 34'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_stb) begin
            case (cmd_op)
              2'b10: begin
                addr_reg   <= cmd_data;
                o_rsp_word <= {2'b10, cmd_data};
                o_rsp_stb  <= 1'b1;
                state      <= RESP;
              end
              2'b00, 2'b01: begin
                o_wb_we   <= cmd_op[0];
                if (cmd_op[0]) o_wb_data <= cmd_data;
                o_wb_addr <= addr_reg;
                o_wb_cyc  <= 1'b1;
                o_wb_stb  <= 1'b1;
                tmo_cnt   <= '0;
                state     <= BUS;
              end
              default: ;
            endcase
          end
        end
        BUS, WAIT_ACK: begin
          if (take_err || take_ack || timed_out) begin
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_rsp_stb <= 1'b1;
            state     <= RESP;
            if (take_ack) begin
              o_rsp_word <= o_wb_we ? {2'b01, o_wb_addr} : {2'b00, i_wb_data};
              addr_reg   <= addr_reg + 32'(ADDR_INC);
            end else begin
              o_rsp_word <= {2'b11, o_wb_addr};
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if ((state == BUS) && !i_wb_stall) begin
              o_wb_stb <= 1'b0;
              state    <= WAIT_ACK;
            end
          end
        end
        RESP: begin
          if (!i_rsp_busy) begin
            o_rsp_stb <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/wb_cmd_sequencer.md
WB_CMD_SEQUENCER -- requirements
Module: wb_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles from o_wb_cyc rise to ack/err before abort.
REQ-002 SHALL have parameter ADDR_INC, default 1, address increment after each completed read/write.
REQ-003 SHALL have i_clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have i_reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have i_cmd_stb  in  1  command word valid, one-cycle pulse.
REQ-006 SHALL have i_cmd_word  in  34  [33:32] opcode (00 read, 01 write, 10 set address, 11 special), [31:0] data.
REQ-007 SHALL have o_cmd_busy  out  1  high whenever state != IDLE.
REQ-008 SHALL have o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  pipelined Wishbone master controls.
REQ-009 SHALL have o_wb_addr, o_wb_data  out  32 each  bus address, write data.
REQ-010 SHALL have i_wb_ack, i_wb_stall, i_wb_err  in  1 each  slave handshake.
REQ-011 SHALL have i_wb_data  in  32  read data.
REQ-012 SHALL have o_rsp_stb  out  1, o_rsp_word  out  34, i_rsp_busy  in  1  response channel to UART encoder.

Function
REQ-013 SHALL implement states IDLE, BUS, WAIT_ACK, RESP.
REQ-014 SHALL accept a command only in IDLE with i_cmd_stb=1; i_cmd_stb in any other state is dropped without effect.
REQ-015 Opcode 10 SHALL load address register from data[31:0], go to RESP with o_rsp_word={2'b10, new address}; o_rsp_stb high the cycle after acceptance.
REQ-016 Opcode 00/01 SHALL latch o_wb_we (=opcode[0]) and o_wb_data (write: data[31:0]), drive o_wb_addr=address register, assert o_wb_cyc=o_wb_stb=1 the cycle after acceptance, enter BUS.
REQ-017 Opcode 11 SHALL be ignored: remain IDLE, no bus cycle, no response.
REQ-018 In BUS, o_wb_stb SHALL stay high until sampled with i_wb_stall=0; then deassert stb and enter WAIT_ACK, o_wb_cyc held.
REQ-019 i_wb_ack or i_wb_err sampled in BUS with i_wb_stall=0 SHALL complete the transfer directly (skip WAIT_ACK); ack/err with stall=1 SHALL be ignored.
REQ-020 On ack: drop cyc/stb next cycle, enter RESP; read -> {2'b00, i_wb_data captured at ack}; write -> {2'b01, transfer address}.
REQ-021 On err: drop cyc/stb, enter RESP with {2'b11, transfer address}; address register NOT incremented.
REQ-022 Timeout counter SHALL clear on cyc assertion, count each cycle cyc is high; at count TIMEOUT_CYCLES-1 without ack/err, drop cyc/stb, respond {2'b11, transfer address}, no increment.
REQ-023 Ack and err in same cycle SHALL be treated as err; ack/err on timeout cycle SHALL win over timeout.
REQ-024 After successful read/write, address register SHALL add ADDR_INC modulo 2^32 (0xFFFFFFFF+1 -> 0).
REQ-025 In RESP, o_rsp_stb and o_rsp_word SHALL hold stable until a cycle with i_rsp_busy=0; then o_rsp_stb falls next cycle and state returns to IDLE.
REQ-026 ack/err/stall sampled while o_wb_cyc=0 SHALL be ignored.
REQ-027 o_wb_stb SHALL never be high while o_wb_cyc is low.

Reset
REQ-028 i_reset SHALL force IDLE, address register 0, timeout counter 0, o_wb_cyc=o_wb_stb=o_wb_we=0, o_wb_addr=o_wb_data=0, o_rsp_stb=0, o_rsp_word=0, o_cmd_busy=0, effective on the next edge.
REQ-029 Reset mid-transfer or mid-RESP SHALL abort with no response and no address increment; a later ack SHALL be ignored.
REQ-030 i_cmd_stb coincident with i_reset SHALL be dropped.

Verification
REQ-031 Set address: cmd {10,0x00000040} -> next cycle o_rsp_stb=1, o_rsp_word={10,0x00000040}; address=0x40.
REQ-032 Write with stall: addr 0x40, cmd {01,0xDEADBEEF}, stall 3 cycles, ack 2 cycles later -> stb high 4 cycles, cyc until ack, rsp {01,0x40}, address 0x41.
REQ-033 Read, ack with stall=0 in BUS: i_wb_data=0x12345678 -> rsp {00,0x12345678}, no WAIT_ACK cycle, address increments.
REQ-034 Timeout: TIMEOUT_CYCLES=16, no ack -> cyc high exactly 16 cycles, rsp {11,addr}, address unchanged; err+ack same cycle -> rsp {11,addr}.
REQ-035 Backpressure/drop: i_rsp_busy=1 for 5 cycles -> rsp word stable throughout; i_cmd_stb during BUS/RESP -> no effect.
REQ-036 Wrap and reset: address 0xFFFFFFFF read ok -> address 0; i_reset during WAIT_ACK -> cyc=0 next cycle, later ack ignored, no response.
